// File: rtl/fullconnect_pkg.sv
// ---------------------------------------------------------------------------
// fullconnect_pkg
// Shared constants, helpers and the beat type used by the full-connect
// write path. The beat struct is sized for the default Avalon width so that
// other blocks (and benches) can exchange whole beats as one value.
// ---------------------------------------------------------------------------
package fullconnect_pkg;

    localparam int FC_ELEM_WIDTH        = 32;
    localparam int FC_AVALON_DATA_WIDTH = 512;

    // Number of MAC results that fit in one Avalon beat.
    function automatic int fc_lanes(input int avalonWidth, input int elemWidth);
        return avalonWidth / elemWidth;
    endfunction

    // One byte-enable bit per data byte.
    function automatic int fc_be_width(input int avalonWidth);
        return avalonWidth / 8;
    endfunction

    localparam int FC_LANES    = fc_lanes(FC_AVALON_DATA_WIDTH, FC_ELEM_WIDTH);
    localparam int FC_BE_WIDTH = fc_be_width(FC_AVALON_DATA_WIDTH);

    typedef struct packed {
        logic [FC_AVALON_DATA_WIDTH-1:0] data;
        logic [FC_BE_WIDTH-1:0]          byteenable;
    } fc_beat_t;

endpackage

// File: rtl/fullconnect_sync_fifo.sv
// ---------------------------------------------------------------------------
// fullconnect_sync_fifo
// Small single-clock FIFO holding completed Avalon beats.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry, straight from storage
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   count_o       : number of entries held
// A push and pop on the same edge keep the count, even at count 1, where the
// pushed entry becomes the new head.
// ---------------------------------------------------------------------------
module fullconnect_sync_fifo #(
    parameter int WIDTH = 576,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    // Guard the raw requests so an overflowing push or underflowing pop can
    // never corrupt the pointers.
    always_comb begin
        doPush = push_i & ~full_o;
        doPop  = pop_i & ~empty_o;
    end

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // head reads as zero until the first beat arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= push_data_i;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Status and head are decoded purely from registered state.
    always_comb begin
        head_o  = mem_q[rdPtr_q];
        full_o  = (count_q == CNT_W'(DEPTH));
        empty_o = (count_q == '0);
        count_o = count_q;
    end

endmodule

// File: rtl/fullconnect_pack_writebuffer.sv
// ---------------------------------------------------------------------------
// fullconnect_pack_writebuffer
// Packs successive MAC results into Avalon beats (lane 0 first) and queues
// completed beats for the write master.
//   clk, rst            : clock, asynchronous active-high reset
//   valid_i/last_i      : MAC result valid; last_i closes the current beat
//   data_i              : MAC result
//   halt_o              : element not taken this cycle (FIFO full)
//   write_data_o        : FIFO head beat
//   write_byteenable_o  : byte-enables of the head beat
//   write_req_o         : FIFO non-empty
//   write_ack_i         : master consumed the head beat
//   fill_level_o        : beats queued
// ---------------------------------------------------------------------------
module fullconnect_pack_writebuffer
    import fullconnect_pkg::*;
#(
    parameter int AVALON_DATA_WIDTH = FC_AVALON_DATA_WIDTH,
    parameter int ELEM_WIDTH        = FC_ELEM_WIDTH,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic                           last_i,
    input  logic [ELEM_WIDTH-1:0]          data_i,
    output logic                           halt_o,
    output logic [AVALON_DATA_WIDTH-1:0]   write_data_o,
    output logic [AVALON_DATA_WIDTH/8-1:0] write_byteenable_o,
    output logic                           write_req_o,
    input  logic                           write_ack_i,
    output logic [$clog2(FIFO_DEPTH):0]    fill_level_o
);

    localparam int LANES      = fc_lanes(AVALON_DATA_WIDTH, ELEM_WIDTH);
    localparam int BE_WIDTH   = fc_be_width(AVALON_DATA_WIDTH);
    localparam int ELEM_BYTES = ELEM_WIDTH / 8;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W     = AVALON_DATA_WIDTH + BE_WIDTH;

    logic [AVALON_DATA_WIDTH-1:0] pack_q;
    logic [AVALON_DATA_WIDTH-1:0] pack_d;
    logic [LANE_W-1:0]            lane_q;
    logic [LANE_W-1:0]            lane_d;
    logic [AVALON_DATA_WIDTH-1:0] beatData;
    logic [BE_WIDTH-1:0]          beatBe;
    logic                         fifoFull;
    logic                         fifoEmpty;
    logic [CNT_W-1:0]             fifoCount;
    logic [BEAT_W-1:0]            fifoHead;
    logic                         accept;
    logic                         beatDone;
    logic                         pop;

    // Back-pressure looks only at the registered occupancy, so a same-cycle
    // ack never lifts halt and there is no path from write_ack_i.
    always_comb begin
        halt_o   = valid_i & fifoFull;
        accept   = valid_i & ~fifoFull;
        beatDone = accept & (last_i | (lane_q == LANE_W'(LANES - 1)));
        pop      = write_req_o & write_ack_i;
    end

    // Candidate beat: lanes below the current one come from the pack
    // register, the current lane takes the incoming element, and anything
    // above stays zero with its byte-enables cleared.
    always_comb begin
        beatData = '0;
        beatBe   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (LANE_W'(k) < lane_q) begin
                beatData[k*ELEM_WIDTH +: ELEM_WIDTH] = pack_q[k*ELEM_WIDTH +: ELEM_WIDTH];
                beatBe[k*ELEM_BYTES +: ELEM_BYTES]   = '1;
            end else if (LANE_W'(k) == lane_q) begin
                beatData[k*ELEM_WIDTH +: ELEM_WIDTH] = data_i;
                beatBe[k*ELEM_BYTES +: ELEM_BYTES]   = '1;
            end
        end
    end

    // Next pack state: a finished beat leaves for the FIFO and the packer
    // restarts at lane 0; otherwise an accepted element just advances.
    always_comb begin
        pack_d = pack_q;
        lane_d = lane_q;
        if (beatDone) begin
            pack_d = '0;
            lane_d = '0;
        end else if (accept) begin
            pack_d = beatData;
            lane_d = lane_q + LANE_W'(1);
        end
    end

    // Pack register and lane counter; reset drops any partial beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q <= '0;
            lane_q <= '0;
        end else begin
            pack_q <= pack_d;
            lane_q <= lane_d;
        end
    end

    fullconnect_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (beatDone),
        .push_data_i ({beatData, beatBe}),
        .pop_i       (pop),
        .head_o      (fifoHead),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .count_o     (fifoCount)
    );

    // Master-facing outputs come straight from FIFO state.
    always_comb begin
        write_data_o       = fifoHead[BEAT_W-1:BE_WIDTH];
        write_byteenable_o = fifoHead[BE_WIDTH-1:0];
        write_req_o        = ~fifoEmpty;
        fill_level_o       = fifoCount;
    end

endmodule

// File: tb/tb_fullconnect_pack_writebuffer.sv
// ---------------------------------------------------------------------------
// tb_fullconnect_pack_writebuffer
// Directed bench: stimulus pushes hand-built expected beats into a queue and
// an independent monitor compares each beat as the master consumes it.
// ---------------------------------------------------------------------------
module tb_fullconnect_pack_writebuffer;
    import fullconnect_pkg::*;

    localparam int AW    = 512;
    localparam int EW    = 32;
    localparam int BEW   = 64;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic              last_i;
    logic [EW-1:0]     data_i;
    logic              halt_o;
    logic [AW-1:0]     write_data_o;
    logic [BEW-1:0]    write_byteenable_o;
    logic              write_req_o;
    logic              write_ack_i;
    logic [2:0]        fill_level_o;

    int       checks = 0;
    int       errors = 0;
    fc_beat_t expQ[$];

    always #5 clk = ~clk;

    fullconnect_pack_writebuffer #(
        .AVALON_DATA_WIDTH (AW),
        .ELEM_WIDTH        (EW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_i            (valid_i),
        .last_i             (last_i),
        .data_i             (data_i),
        .halt_o             (halt_o),
        .write_data_o       (write_data_o),
        .write_byteenable_o (write_byteenable_o),
        .write_req_o        (write_req_o),
        .write_ack_i        (write_ack_i),
        .fill_level_o       (fill_level_o)
    );

    // Expected beat with n lanes holding base, base+1, ... and the rest zero.
    function automatic fc_beat_t makeBeat(input int n, input logic [31:0] base);
        fc_beat_t b;
        b = '0;
        for (int k = 0; k < n; k++) begin
            b.data[k*32 +: 32]     = base + 32'(k);
            b.byteenable[k*4 +: 4] = 4'hF;
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer one element and hold it until taken; a halt longer than the
    // bound counts as a failure and the bench moves on.
    task automatic applyStimulus(input logic [31:0] d, input logic l);
        logic h;
        int   n;
        n       = 0;
        valid_i = 1'b1;
        last_i  = l;
        data_i  = d;
        do begin
            #1;
            h = halt_o;
            @(posedge clk);
            #2;
            n++;
        end while (h && n < 200);
        if (h) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: element %0h still halted after %0d cycles", d, n);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic sendRun(input int n, input logic [31:0] base, input logic lastAtEnd);
        for (int i = 0; i < n; i++) begin
            applyStimulus(base + 32'(i), lastAtEnd && (i == n - 1));
        end
    endtask

    // Ack until the FIFO empties, bounded; the monitor checks each beat.
    task automatic drain();
        write_ack_i = 1'b1;
        for (int i = 0; i < 100 && write_req_o; i++) begin
            @(posedge clk);
            #2;
        end
        write_ack_i = 1'b0;
        checkOutput("drainReq", AW'(write_req_o), AW'(0));
        checkOutput("scoreboardEmpty", AW'(expQ.size()), AW'(0));
    endtask

    // Monitor: on every beat the master takes, compare against the queue.
    always @(negedge clk) begin
        if (!rst && write_req_o && write_ack_i) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedBeat: got data %0h be %0h, expected none",
                         write_data_o, write_byteenable_o);
            end else begin
                fc_beat_t e;
                e = expQ.pop_front();
                if (write_data_o !== e.data || write_byteenable_o !== e.byteenable) begin
                    errors++;
                    $display("[TB] FAIL beat: got data %0h be %0h, expected data %0h be %0h",
                             write_data_o, write_byteenable_o, e.data, e.byteenable);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        valid_i     = 1'b0;
        last_i      = 1'b0;
        data_i      = '0;
        write_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstReq",  AW'(write_req_o), AW'(0));
        checkOutput("rstHalt", AW'(halt_o), AW'(0));
        checkOutput("rstData", write_data_o, AW'(0));
        checkOutput("rstBe",   AW'(write_byteenable_o), AW'(0));
        checkOutput("rstFill", AW'(fill_level_o), AW'(0));
        rst = 1'b0;
        @(posedge clk);
        #2;

        $display("[TB] full beat of 16 elements");
        sendRun(15, 32'h1, 1'b0);
        checkOutput("fullBeatReqEarly", AW'(write_req_o), AW'(0));
        applyStimulus(32'h10, 1'b0);
        expQ.push_back(makeBeat(16, 32'h1));
        checkOutput("fullBeatReq",  AW'(write_req_o), AW'(1));
        checkOutput("fullBeatFill", AW'(fill_level_o), AW'(1));
        checkOutput("fullBeatBe",   AW'(write_byteenable_o), AW'({BEW{1'b1}}));
        drain();

        $display("[TB] partial beat closed by last");
        applyStimulus(32'hA, 1'b0);
        last_i = 1'b1;
        @(posedge clk);
        #2;
        last_i = 1'b0;
        checkOutput("lastWithoutValid", AW'(write_req_o), AW'(0));
        applyStimulus(32'hB, 1'b0);
        applyStimulus(32'hC, 1'b1);
        expQ.push_back(makeBeat(3, 32'hA));
        checkOutput("partialBe",   AW'(write_byteenable_o), AW'(64'hFFF));
        checkOutput("partialData", write_data_o, AW'({32'hC, 32'hB, 32'hA}));
        drain();

        $display("[TB] fill FIFO and back-pressure");
        sendRun(64, 32'h100, 1'b0);
        for (int j = 0; j < 4; j++) begin
            expQ.push_back(makeBeat(16, 32'h100 + 32'(16 * j)));
        end
        checkOutput("fullFill", AW'(fill_level_o), AW'(4));
        valid_i = 1'b1;
        data_i  = 32'h140;
        #1;
        checkOutput("haltOn65", AW'(halt_o), AW'(1));
        @(posedge clk);
        #2;
        checkOutput("haltHeld", AW'(halt_o), AW'(1));
        write_ack_i = 1'b1;
        #1;
        checkOutput("haltIgnoresAck", AW'(halt_o), AW'(1));
        @(posedge clk);
        #2;
        write_ack_i = 1'b0;
        checkOutput("fillAfterPop", AW'(fill_level_o), AW'(3));
        checkOutput("haltReleased", AW'(halt_o), AW'(0));
        @(posedge clk);
        #2;
        valid_i = 1'b0;
        sendRun(15, 32'h141, 1'b0);
        expQ.push_back(makeBeat(16, 32'h140));
        checkOutput("refillFill", AW'(fill_level_o), AW'(4));
        drain();

        $display("[TB] push and pop on the same edge at level 1");
        sendRun(16, 32'h200, 1'b0);
        expQ.push_back(makeBeat(16, 32'h200));
        sendRun(15, 32'h300, 1'b0);
        checkOutput("level1Fill", AW'(fill_level_o), AW'(1));
        write_ack_i = 1'b1;
        applyStimulus(32'h30F, 1'b0);
        write_ack_i = 1'b0;
        expQ.push_back(makeBeat(16, 32'h300));
        checkOutput("pushPopFill", AW'(fill_level_o), AW'(1));
        checkOutput("pushPopHead", AW'(write_data_o[31:0]), AW'(32'h300));
        checkOutput("pushPopReq",  AW'(write_req_o), AW'(1));
        drain();

        $display("[TB] reset mid-operation");
        sendRun(32, 32'h500, 1'b0);
        sendRun(5, 32'h600, 1'b0);
        checkOutput("preResetFill", AW'(fill_level_o), AW'(2));
        rst = 1'b1;
        #1;
        checkOutput("midRstReq",  AW'(write_req_o), AW'(0));
        checkOutput("midRstFill", AW'(fill_level_o), AW'(0));
        checkOutput("midRstData", write_data_o, AW'(0));
        checkOutput("midRstBe",   AW'(write_byteenable_o), AW'(0));
        checkOutput("midRstHalt", AW'(halt_o), AW'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        sendRun(15, 32'h400, 1'b0);
        checkOutput("postRstEarly", AW'(write_req_o), AW'(0));
        applyStimulus(32'h40F, 1'b0);
        expQ.push_back(makeBeat(16, 32'h400));
        checkOutput("postRstReq", AW'(write_req_o), AW'(1));
        checkOutput("postRstBe",  AW'(write_byteenable_o), AW'({BEW{1'b1}}));

        $display("[TB] single-lane beat via last on lane 0");
        drain();
        applyStimulus(32'hDEADBEEF, 1'b1);
        expQ.push_back(makeBeat(1, 32'hDEADBEEF));
        checkOutput("oneLaneBe",   AW'(write_byteenable_o), AW'(64'hF));
        checkOutput("oneLaneFill", AW'(fill_level_o), AW'(1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
